// File: rtl/approx_mult_pkg.sv
// Shared constants, rdata field slices and the reader FSM state type for the
// approximate-multiplier result path.
package approx_mult_pkg;

  localparam int N_WORDS = 16;
  localparam int ADDR_W  = 4;
  localparam int WIN_W   = 8;
  localparam int SH_W    = 5;
  localparam int OUT_W   = 16;
  localparam int WORD_W  = SH_W + WIN_W;

  // Shift counts at or above this value encode a zero product.
  localparam int ZERO_TH = 16;

  // Field layout of a stored result word, shared with the writer side.
  localparam int SH_MSB  = 12;
  localparam int SH_LSB  = 8;
  localparam int WIN_MSB = 7;
  localparam int WIN_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_READ  = 3'd2,
    S_LATCH = 3'd3,
    S_SHIFT = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } reader_state_e;

endpackage

// File: rtl/approx_result_reader_if.sv
// Result-memory read port plus the product output stream.
// Stream handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 the producer holds
// out_data and out_last stable, and out_valid never drops without a transfer.
interface approx_result_reader_if;
  import approx_mult_pkg::*;

  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic [WORD_W-1:0] rdata;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output ren, raddr, out_data, out_valid, out_last,
    input  rdata, out_ready
  );

  modport slave (
    input  ren, raddr, out_data, out_valid, out_last,
    output rdata, out_ready
  );

endinterface

// File: rtl/approx_decode_shifter.sv
// Decodes a stored {shift, window} word and rebuilds the product by shifting
// the left-aligned window right one bit per cycle.
module approx_decode_shifter
  import approx_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [OUT_W-1:0]  shreg_o,
  output logic              shift_done_o
);

  logic [OUT_W-1:0] shreg_q, shreg_d;
  logic [SH_W-1:0]  shcnt_q, shcnt_d;
  logic [SH_W-1:0]  s_field;
  logic [WIN_W-1:0] w_field;

  assign s_field = word_i[SH_MSB:SH_LSB];
  assign w_field = word_i[WIN_MSB:WIN_LSB];

  // Load a new word (or the zero encoding), otherwise walk the shift count down.
  always_comb begin
    shreg_d = shreg_q;
    shcnt_d = shcnt_q;
    if (load_i) begin
      if (s_field < SH_W'(ZERO_TH)) begin
        shreg_d = {w_field, {(OUT_W-WIN_W){1'b0}}};
        shcnt_d = s_field;
      end else begin
        shreg_d = '0;
        shcnt_d = '0;
      end
    end else if (shift_i && (shcnt_q != '0)) begin
      shreg_d = shreg_q >> 1;
      shcnt_d = shcnt_q - SH_W'(1);
    end
  end

  // Shift register and remaining-shift counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
      shcnt_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      shcnt_q <= shcnt_d;
    end
  end

  assign shreg_o      = shreg_q;
  assign shift_done_o = (shcnt_q == '0);

endmodule

// File: rtl/approx_result_reader.sv
// Walks the result memory once per run, rebuilds each approximate product and
// streams it out with valid/ready, pulsing done after the last word.
module approx_result_reader
  import approx_mult_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  approx_result_reader_if.master bus,
  output logic                   busy,
  output logic                   done,
  output reader_state_e          state_dbg_o
);

  reader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic             load;
  logic             shift_en;
  logic             shift_done;
  logic [OUT_W-1:0] shreg;
  logic             is_last;
  logic             ren;
  logic             out_valid;
  logic             out_last;

  assign is_last = (cnt_q == ADDR_W'(N_WORDS-1));

  approx_decode_shifter u_shifter (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .shift_i      (shift_en),
    .word_i       (bus.rdata),
    .shreg_o      (shreg),
    .shift_done_o (shift_done)
  );

  // Next-state, word counter and per-state output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    ren       = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        if (!start) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        busy    = 1'b1;
        ren     = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        busy    = 1'b1;
        load    = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (shift_done) state_d = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = is_last;
        if (bus.out_ready) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            cnt_d   = cnt_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and word counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // raddr follows the counter, which only moves on entry to READ.
  assign bus.raddr     = cnt_q;
  assign bus.ren       = ren;
  assign bus.out_data  = shreg;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign state_dbg_o   = state_q;

endmodule
